// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and width helpers for the shared register arbiter.
package shared_reg_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Rotating-priority scan: first set request at or after ptr, wrapping at N.
module rr_priority_pick #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            any_req,
    output logic [IDXW-1:0] win_idx,
    output logic [N-1:0]    win_oh
);

    int               j;
    logic [IDXW-1:0]  idx;

    // Scan from the farthest offset down so the nearest match is written last.
    always_comb begin
        j       = 0;
        idx     = '0;
        win_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            idx = IDXW'(j);
            if (req[idx]) win_idx = idx;
        end
    end

    always_comb begin
        any_req         = |req;
        win_oh          = '0;
        win_oh[win_idx] = any_req;
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared W-bit register with a fixed hold time
// after every capture.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int HOLD = 2,
    localparam int IDXW = idx_w(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    din,
    output logic [N-1:0]      gnt,
    output logic [W-1:0]      q,
    output logic [IDXW-1:0]   q_owner,
    output logic              q_valid
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((HOLD > 0) ? HOLD - 1 : 0);

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [CW-1:0]   cnt;

    logic            any_req;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    win_oh;
    logic [IDXW-1:0] ptr_nxt;

    rr_priority_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .any_req (any_req),
        .win_idx (win_idx),
        .win_oh  (win_oh)
    );

    // Explicit wrap so non-power-of-two N stays in range.
    assign ptr_nxt = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            q       <= '0;
            q_owner <= '0;
            q_valid <= 1'b0;
        end else begin
            gnt <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        q       <= din[win_idx*W +: W];
                        q_owner <= win_idx;
                        q_valid <= 1'b1;
                        gnt     <= win_oh;
                        ptr     <= ptr_nxt;
                        if (HOLD > 0) begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench: a HOLD=2 and a HOLD=0 arbiter share stimulus and are
// checked every cycle against a spec-level reference model.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] q;
        logic [1:0]   own;
        logic         val;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;

    logic [N-1:0] gnt_a, gnt_b;
    logic [W-1:0] q_a, q_b;
    logic [1:0]   own_a, own_b;
    logic         val_a, val_b;

    int passed = 0;
    int total  = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int           m_ptr  [2];
    int           m_busy [2];
    logic [W-1:0] m_q    [2];
    int           m_own  [2];
    logic         m_val  [2];
    int           m_hold [2];

    shared_reg_arbiter #(.N(N), .W(W), .HOLD(2)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt_a),
        .q       (q_a),
        .q_owner (own_a),
        .q_valid (val_a)
    );

    shared_reg_arbiter #(.N(N), .W(W), .HOLD(0)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt_b),
        .q       (q_b),
        .q_owner (own_b),
        .q_valid (val_b)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    // Reference: an arbiter that is free when its busy budget is spent
    // picks the first requester found going round from its pointer.
    function automatic exp_t predict(input int i);
        exp_t e;
        e.gnt = '0;
        if (!rst_n) begin
            m_ptr[i] = 0; m_busy[i] = 0; m_q[i] = '0;
            m_own[i] = 0; m_val[i] = 1'b0;
        end else if (m_busy[i] > 0) begin
            m_busy[i]--;
        end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
                int w;
                w = (m_ptr[i] + k) % N;
                if (req[w]) begin
                    m_q[i]    = din[w*W +: W];
                    m_own[i]  = w;
                    m_val[i]  = 1'b1;
                    m_ptr[i]  = (w + 1) % N;
                    m_busy[i] = m_hold[i];
                    e.gnt     = N'(1) << w;
                    break;
                end
            end
        end
        e.q   = m_q[i];
        e.own = 2'(m_own[i]);
        e.val = m_val[i];
        return e;
    endfunction

    task automatic apply(input logic r, input logic [N-1:0] rq,
                         input logic [N*W-1:0] d);
        rst_n = r;
        req   = rq;
        din   = d;
        sb_a.push_back(predict(0));
        sb_b.push_back(predict(1));
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] rq,
                       input logic [N*W-1:0] d);
        @(negedge clk);
        apply(r, rq, d);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_gnt_a"}, 32'(gnt_a), 0);
        chk({tag, "_q_a"},   32'(q_a),   0);
        chk({tag, "_own_a"}, 32'(own_a), 0);
        chk({tag, "_val_a"}, 32'(val_a), 0);
        chk({tag, "_gnt_b"}, 32'(gnt_b), 0);
        chk({tag, "_q_b"},   32'(q_b),   0);
        chk({tag, "_val_b"}, 32'(val_b), 0);
    endtask

    // Monitor: every edge the DUTs present a new output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_a.size() == 0) begin
                chk("sb_a_empty", 1, 0);
            end else begin
                e = sb_a.pop_front();
                chk("gnt_a", 32'(gnt_a), 32'(e.gnt));
                chk("q_a",   32'(q_a),   32'(e.q));
                chk("own_a", 32'(own_a), 32'(e.own));
                chk("val_a", 32'(val_a), 32'(e.val));
            end
            if (sb_b.size() == 0) begin
                chk("sb_b_empty", 1, 0);
            end else begin
                e = sb_b.pop_front();
                chk("gnt_b", 32'(gnt_b), 32'(e.gnt));
                chk("q_b",   32'(q_b),   32'(e.q));
                chk("own_b", 32'(own_b), 32'(e.own));
                chk("val_b", 32'(val_b), 32'(e.val));
            end
        end
    end

    initial begin
        logic [N*W-1:0] dd;
        m_hold[0] = 2;
        m_hold[1] = 0;
        dd = {8'h44, 8'h33, 8'h22, 8'h11};

        apply(1'b0, 4'b1111, {N{8'hFF}});
        #1 outs_zero("rst_init");
        cyc(1'b0, 4'b1111, {N{8'hFF}});
        cyc(1'b1, 4'b0000, '0);

        repeat (8) cyc(1'b1, 4'b0010, {8'h00, 8'h00, 8'hA5, 8'h00});
        repeat (16) cyc(1'b1, 4'b1111, dd);

        cyc(1'b0, 4'b0000, '0);
        repeat (2) cyc(1'b1, 4'b1000, dd);
        repeat (3) cyc(1'b1, 4'b1010, dd);
        repeat (3) cyc(1'b1, 4'b0010, dd);
        repeat (3) cyc(1'b1, 4'b0011, dd);

        repeat (6) cyc(1'b1, 4'b1001, dd);

        cyc(1'b1, 4'b0100, dd);
        cyc(1'b0, 4'b0100, dd);
        #1 outs_zero("rst_busy");
        repeat (4) cyc(1'b1, 4'b0100, dd);

        repeat (400) begin
            cyc(($urandom_range(0, 99) != 0), N'($urandom_range(0, 15)),
                {$urandom(), 32'(0)} >> 32);
        end

        @(posedge clk);
        #3;
        chk("sb_drained", 32'(sb_a.size() + sb_b.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one W-bit storage register between N requesters.
- Each requester presents data and a request. The arbiter picks one winner, captures its data into the shared register, and returns a one-cycle grant pulse.
- The register then stays reserved for HOLD cycles before the next arbitration, which models a resource with a fixed occupancy time.
- Sits between requester logic and any consumer of the shared register value.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, data width per requester and of the shared register.
- HOLD, 2, idle cycles after each capture during which no arbitration occurs (0 = back-to-back grants).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector, bit i = requester i
- din  input  N*W  packed data, requester i at bits [i*W +: W]
- gnt  output  N  one-hot grant pulse, registered
- q  output  W  shared register contents
- q_owner  output  IDXW  index of requester that last wrote q
- q_valid  output  1  high once q has been written at least once since reset

Behaviour:
- Reset (async, rst_n=0):
  - Immediately forces gnt=0, q=0, q_owner=0, q_valid=0.
  - Sets rr pointer ptr=0, state=IDLE, hold counter=0.
  - Takes effect with no clock edge. A reset mid-BUSY discards the reservation.
- States: IDLE, BUSY.
- IDLE, at a rising edge with req!=0:
  - winner = first set bit of req, scanning ptr, ptr+1, ... ptr+N-1, with indices modulo N.
  - Same edge: q<=din[winner], q_owner<=winner, q_valid<=1, gnt<=onehot(winner), ptr<=(winner+1) mod N.
  - If HOLD>0, go to BUSY with cnt<=HOLD-1; else stay IDLE.
- IDLE with req=0: gnt<=0, nothing else changes.
- BUSY:
  - gnt<=0 on every edge.
  - req is ignored. Requests are not queued; only the live req level is sampled.
  - If cnt==0, go to IDLE; else cnt<=cnt-1.
  - BUSY therefore lasts exactly HOLD cycles.
- Timing:
  - Latency from a req sampled in IDLE to gnt/q update is 1 edge; gnt is high for exactly one cycle.
  - With HOLD=0 and continuous requests, gnt may stay high on consecutive cycles, moving between requesters.
  - Minimum spacing between grants is HOLD+1 cycles.
- Handshake:
  - Requester holds req and din stable until it sees gnt[i]=1, then may drop req in the same cycle.
  - Dropping req before a grant is legal and leaves no side effect.
  - A req held after its grant re-competes at the lowest priority (fairness from the ptr update).
- Wrap-around: ptr=N-1 with winner N-1 gives ptr=0. The scan wraps from N-1 to 0.
- Simultaneous events: multiple requests are resolved purely by the rr scan, with no fixed priority beyond ptr. A request arriving in the same cycle BUSY ends is not granted until the first IDLE edge.
- Widths: IDXW = max(1, clog2(N)). ptr and q_owner are IDXW bits. The modulo-N increment must not assume N is a power of two.
- q is written only on a grant edge and holds its value otherwise, including through BUSY.

Decomposition:
- Shared package: state encoding (IDLE, BUSY) and the IDXW width function/constant.
- One combinational sub-module, rr_priority_pick.
  - Inputs: req, ptr.
  - Outputs: any_req, winner index, winner one-hot.
  - It holds the rotating-priority scan; the top level holds the FSM, counter and registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 and din all 8'hFF -> gnt=0, q=8'h00, q_valid=0, q_owner=0 throughout.
- Single request: req=4'b0010, din[1]=8'hA5, HOLD=2, req held.
  - -> after 1 edge: gnt=4'b0010 for one cycle, q=8'hA5, q_owner=1, q_valid=1.
  - -> next gnt exactly 3 cycles later.
- Fairness: req=4'b1111 held, distinct din values -> grant order 0,1,2,3,0. Grants are 3 cycles apart and q tracks the matching din each time.
- Wrap: grant requester 3 (ptr becomes 0), then req=4'b1010 -> grant goes to 1. Then grant requester 1 (ptr=2), then req=4'b0011 -> grant goes to 0.
- HOLD=0 instance: req=4'b1001 held -> gnt alternates 4'b0001, 4'b1000, 4'b0001 on consecutive cycles, with no idle cycle between grants.
- Async reset mid-BUSY: assert rst_n=0 between edges -> all outputs clear immediately. After release with req=4'b0100, the first grant goes to requester 2 one edge later.
